// File: rtl/avalon_master_pkg.sv
// Shared types and constants for the FFT result write-back master.
package avalon_master_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] AV_RESP_OKAY = 2'b00;

  // Bit width needed to hold values 0..n-1, never less than one bit.
  function automatic int width_for(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/avalon_result_master_if.sv
// Avalon-MM write-master bus with write-response channel.
interface avalon_result_master_if #(
  parameter int AV_AW  = 16,
  parameter int DATA_W = 16
);
  logic              master_write;
  logic [AV_AW-1:0]  master_address;
  logic [DATA_W-1:0] master_write_data;
  logic              master_waitrequest;
  logic              master_writeresponsevalid;
  logic [1:0]        master_response;

  modport master (
    output master_write, master_address, master_write_data,
    input  master_waitrequest, master_writeresponsevalid, master_response
  );

  modport slave (
    input  master_write, master_address, master_write_data,
    output master_waitrequest, master_writeresponsevalid, master_response
  );
endinterface

// File: rtl/result_prefetch_fifo.sv
// Two-entry prefetch FIFO between the local sample buffer and the Avalon write port.
module result_prefetch_fifo #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [1:0]        count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              do_push, do_pop;

  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != 2'd2) || do_pop);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) rd_ptr_d = ~rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      // NOTE: storage is reset too, because the head drives the bus data and must read 0 out of reset.
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/avalon_result_master.sv
// Streams FFT results from the local buffer into Avalon-MM writes, tracking responses.
module avalon_result_master
  import avalon_master_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int LOCAL_AW  = 9,
  parameter int N_POINTS  = 512,
  parameter int AV_AW     = 16,
  parameter int BYTE_ADDR = 1,
  parameter int MAX_PEND  = 4
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           fft_done,
  input  logic [AV_AW-1:0]               dest_base,
  input  logic [$clog2(N_POINTS+1)-1:0]  xfer_len,
  output logic                           sReEn,
  output logic [LOCAL_AW-1:0]            sampled_address,
  input  logic [DATA_W-1:0]              sampled_data,
  avalon_result_master_if.master         av,
  output logic                           busy,
  output logic                           xfer_done,
  output logic                           err,
  output logic [LOCAL_AW-1:0]            err_index
);

  localparam int LEN_W  = width_for(N_POINTS + 1);
  localparam int PEND_W = width_for(MAX_PEND + 1);
  localparam logic [AV_AW-1:0]  STRIDE   = (BYTE_ADDR != 0) ? AV_AW'(DATA_W / 8) : AV_AW'(1);
  localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(N_POINTS);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);

  state_e              state_q, state_d;
  logic [AV_AW-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    rd_idx_q, rd_idx_d;
  logic [LEN_W-1:0]    wr_idx_q, wr_idx_d;
  logic [LEN_W-1:0]    rsp_idx_q, rsp_idx_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic                rd_inflight_q, rd_inflight_d;
  logic                err_q, err_d;
  logic [LOCAL_AW-1:0] err_index_q, err_index_d;

  logic              wr_req, accept, rsp_fire, rd_en;
  logic [1:0]        fifo_count;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic [2:0]        occ;

  result_prefetch_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (rd_inflight_q),
    .pop   (accept),
    .din   (sampled_data),
    .dout  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign wr_req   = (state_q == RUN) && !fifo_empty && (pend_q < PEND_MAX);
  assign accept   = wr_req && !av.master_waitrequest;
  assign rsp_fire = av.master_writeresponsevalid && (pend_q != '0);

  // Occupancy after this edge counts the word still in flight and the word leaving now,
  // so a read may issue in the same cycle as a pop and sustain one word per cycle.
  assign occ   = {1'b0, fifo_count} + {2'b00, rd_inflight_q} - {2'b00, accept};
  assign rd_en = (state_q == RUN) && (rd_idx_q < len_q)
                 && !(fifo_full && !accept) && (occ < 3'd2);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    rd_idx_d      = rd_idx_q;
    wr_idx_d      = wr_idx_q;
    rsp_idx_d     = rsp_idx_q;
    pend_d        = pend_q;
    rd_inflight_d = rd_en;
    err_d         = err_q;
    err_index_d   = err_index_q;

    if (accept && !rsp_fire)      pend_d = pend_q + 1'b1;
    else if (!accept && rsp_fire) pend_d = pend_q - 1'b1;

    if (rsp_fire) begin
      rsp_idx_d = rsp_idx_q + 1'b1;
      if ((av.master_response != AV_RESP_OKAY) && !err_q) begin
        err_d       = 1'b1;
        err_index_d = LOCAL_AW'(rsp_idx_q);
      end
    end

    case (state_q)
      IDLE: begin
        if (fft_done) begin
          addr_d        = dest_base;
          len_d         = (xfer_len > LEN_MAX) ? LEN_MAX : xfer_len;
          rd_idx_d      = '0;
          wr_idx_d      = '0;
          rsp_idx_d     = '0;
          pend_d        = '0;
          rd_inflight_d = 1'b0;
          err_d         = 1'b0;
          err_index_d   = '0;
          state_d       = (len_d == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (rd_en) rd_idx_d = rd_idx_q + 1'b1;
        if (accept) begin
          addr_d   = addr_q + STRIDE;
          wr_idx_d = wr_idx_q + 1'b1;
          if (wr_idx_q == len_q - 1'b1) state_d = (pend_d == '0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (pend_d == '0) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      rd_idx_q      <= '0;
      wr_idx_q      <= '0;
      rsp_idx_q     <= '0;
      pend_q        <= '0;
      rd_inflight_q <= 1'b0;
      err_q         <= 1'b0;
      err_index_q   <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      rd_idx_q      <= rd_idx_d;
      wr_idx_q      <= wr_idx_d;
      rsp_idx_q     <= rsp_idx_d;
      pend_q        <= pend_d;
      rd_inflight_q <= rd_inflight_d;
      err_q         <= err_d;
      err_index_q   <= err_index_d;
    end
  end

  assign sReEn                = rd_en;
  assign sampled_address      = LOCAL_AW'(rd_idx_q);
  assign av.master_write      = wr_req;
  assign av.master_address    = addr_q;
  assign av.master_write_data = fifo_head;
  assign busy                 = (state_q == RUN) || (state_q == DRAIN);
  assign xfer_done            = (state_q == DONE);
  assign err                  = err_q;
  assign err_index            = err_index_q;

endmodule
